hs_pipeline: RTL and testbench
==============================

// Module: hs_pipeline
// PURPOSE
//  Clocked, parametrised bundled-data handshake pipeline: DEPTH token stages of WIDTH bits between a
//  req/ack producer and a req/ack consumer. Successor to the single C-element stage: adds depth,
//  width, a 2-/4-phase protocol mode, input synchronisers and occupancy status. Sits between blocks in
//  different timing domains, or between blocks driven by free-running handshake logic.
// PARAMETERS
//  WIDTH        3  data bits per token
//  DEPTH        4  token stages, >=1
//  PHASES       4  handshake protocol, 4 = return-to-zero, 2 = transition signalling
//  SYNC_STAGES  2  flops on req_in and on ack_in, 0..3; 0 = both already synchronous to clk
// PORTS
//  clk       in   1                    rising-edge clock
//  rst       in   1                    asynchronous reset, active-low
//  req_in    in   1                    upstream request; data_in is stable whenever it signals a token
//  ack_out   out  1                    acknowledge to upstream
//  data_in   in   WIDTH                upstream token data
//  req_out   out  1                    request to downstream
//  ack_in    in   1                    acknowledge from downstream
//  data_out  out  WIDTH                head token; stable while a request is outstanding
//  count     out  $clog2(DEPTH+1)      number of valid stages
//  empty     out  1                    count==0
//  full      out  1                    count==DEPTH
// BEHAVIOUR
//  Reset (rst=0, async): all valid bits, data regs, sync flops, req_out and ack_out go to 0;
//   both FSMs go to IDLE; count=0, empty=1, full=0. Mid-operation reset discards all tokens.
//   The environment must reset together with this block. After release, 2-phase levels start at 0.
//  req_s/ack_s: req_in/ack_in after SYNC_STAGES flops. With SYNC_STAGES=0 they are the raw inputs.
//  Stages: valid[k], data[k]; stage 0 is the input, stage DEPTH-1 is the head.
//   move[k] = valid[k] & (~valid[k+1] | move[k+1]); move[DEPTH-1] = pop.
//   A token advances one stage per edge. A full pipe streams at 1 token/edge. No bubble is required.
//   free0 = ~valid[0] | move[0].
//  Input FSM, PHASES=4:
//   IN_IDLE: req_s & free0 -> load stage 0 from data_in, ack_out<=1, go IN_WAIT.
//   IN_WAIT: ~req_s -> ack_out<=0, go IN_IDLE.
//  Input FSM, PHASES=2 (single state): (req_s != ack_out) & free0 -> load stage 0, ack_out<=~ack_out.
//  Output FSM, PHASES=4:
//   OUT_IDLE: valid[head] & ~ack_s -> req_out<=1, go OUT_REQ.
//   OUT_REQ: ack_s -> req_out<=0, pop=1, go OUT_IDLE.
//  Output FSM, PHASES=2:
//   OUT_IDLE: valid[head] & (ack_s==req_out) -> req_out<=~req_out, go OUT_REQ.
//   OUT_REQ: ack_s==req_out -> pop=1, go OUT_IDLE.
//  data_out = data[head] (registered). The head does not move while in OUT_REQ.
//  Latency, empty pipe: req_out signals SYNC_STAGES+DEPTH+1 edges after the first edge that sees req_in
//   active. Push and pop may occur on the same edge; count is unchanged then.
//  Full pipe: a load happens only if the head pops on the same edge, through the move chain.
//   Otherwise req_in is held and ack_out is withheld; no data is lost or overwritten.
//  count is updated on the same edge as each load/pop; empty and full are decoded from count.
//  Other inputs: an ack_in change while in OUT_IDLE, or a req_in drop before ack (protocol violation),
//   changes no stored token.
// STRUCTURE
//  Package hs_pkg holds:
//   - state encodings IN_IDLE/IN_WAIT and OUT_IDLE/OUT_REQ
//   - constants PH_2=2, PH_4=4
//   - the count-width function
//  Sub-module: hs_sync_bit (SYNC_STAGES-deep reset-to-0 flop chain). It is instantiated for req_in
//   and for ack_in. A generate passes the bit through when SYNC_STAGES=0.
//  The stage array and the move chain are a generate loop in this module.
// TESTING
//  1 Reset: drive rst=0 mid-stream with count=3 -> outputs all 0 and count=0 immediately; after release
//    there is no spurious req_out.
//  2 PHASES=4, SYNC=2, DEPTH=4: one token 3'b101, ack_in held 0 -> req_out rises 7 edges after req_in;
//    data_out=3'b101.
//  3 Fill: stall ack_in=0 and push 5 tokens 1..5 -> count=4, full=1; the 5th ack_out is withheld until
//    the first pop. Tokens exit in order 1..5.
//  4 Streaming with SYNC=0: consumer acks in the cycle after each req -> throughput limited by the
//    handshake only. No token is lost or duplicated across 100 random tokens; this is checked against
//    a scoreboard.
//  5 PHASES=2: toggle req_in per token with data 7,0,6 -> ack_out toggles once per token; req_out
//    toggles 3 times; data_out=7,0,6.
//  6 Simultaneous events: push and pop on the same edge at count=2 -> count stays 2; full pipe with a
//    pop -> same-edge load accepted.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared encodings, protocol constants and sizing helper for the bundled-data
// handshake pipeline.
package hs_pkg;

    localparam int unsigned PH_2 = 2;
    localparam int unsigned PH_4 = 4;

    typedef enum logic {
        IN_IDLE = 1'b0,
        IN_WAIT = 1'b1
    } in_state_e;

    typedef enum logic {
        OUT_IDLE = 1'b0,
        OUT_REQ  = 1'b1
    } out_state_e;

    // Width of an occupancy counter able to hold 0..depth.
    function automatic int unsigned count_width(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hs_sync_bit.sv
// Reset-to-zero flop chain that brings one handshake level into the clk domain;
// a zero-length chain passes the input straight through.
module hs_sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign q = d;
        end else begin : g_sync
            logic [STAGES-1:0] sync_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= d;
                    for (int i = 1; i < int'(STAGES); i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end

            assign q = sync_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/hs_pipeline.sv
// Bundled-data req/ack pipeline of DEPTH token stages with 2-/4-phase protocol
// selection, optional input synchronisers and occupancy status.
module hs_pipeline
    import hs_pkg::*;
#(
    parameter int unsigned WIDTH       = 3,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned PHASES      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_in,
    output logic                             ack_out,
    input  logic [WIDTH-1:0]                 data_in,
    output logic                             req_out,
    input  logic                             ack_in,
    output logic [WIDTH-1:0]                 data_out,
    output logic [count_width(DEPTH)-1:0]    count,
    output logic                             empty,
    output logic                             full
);

    localparam int unsigned CW = count_width(DEPTH);

    logic req_s;
    logic ack_s;

    hs_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync_req (
        .clk (clk),
        .rst (rst),
        .d   (req_in),
        .q   (req_s)
    );

    hs_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync_ack (
        .clk (clk),
        .rst (rst),
        .d   (ack_in),
        .q   (ack_s)
    );

    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] move;
    logic             load;
    logic             pop;
    logic             free0;

    // Resolved head-first so a full pipe can shift every stage on a pop.
    always_comb begin
        move            = '0;
        move[DEPTH-1]   = pop;
        for (int k = int'(DEPTH) - 2; k >= 0; k--) begin
            move[k] = valid[k] & (~valid[k+1] | move[k+1]);
        end
    end

    assign free0 = ~valid[0] | move[0];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             stage_valid_q;
        logic [WIDTH-1:0] stage_data_q;
        logic             fill;
        logic [WIDTH-1:0] fill_data;

        if (k == 0) begin : g_first
            assign fill      = load;
            assign fill_data = data_in;
        end else begin : g_rest
            assign fill      = move[k-1];
            assign fill_data = data[k-1];
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                stage_valid_q <= 1'b0;
                stage_data_q  <= '0;
            end else if (fill) begin
                stage_valid_q <= 1'b1;
                stage_data_q  <= fill_data;
            end else if (move[k]) begin
                stage_valid_q <= 1'b0;
            end
        end

        assign valid[k] = stage_valid_q;
        assign data[k]  = stage_data_q;
    end

    // Input side: accepts a token into stage 0 and drives ack_out.
    in_state_e in_state_q, in_state_d;
    logic      ack_out_q, ack_out_d;

    always_comb begin
        in_state_d = in_state_q;
        ack_out_d  = ack_out_q;
        load       = 1'b0;
        if (PHASES == PH_2) begin
            in_state_d = IN_IDLE;
            if ((req_s != ack_out_q) && free0) begin
                load      = 1'b1;
                ack_out_d = ~ack_out_q;
            end
        end else begin
            case (in_state_q)
                IN_IDLE: begin
                    if (req_s && free0) begin
                        load       = 1'b1;
                        ack_out_d  = 1'b1;
                        in_state_d = IN_WAIT;
                    end
                end
                IN_WAIT: begin
                    if (!req_s) begin
                        ack_out_d  = 1'b0;
                        in_state_d = IN_IDLE;
                    end
                end
                default: in_state_d = IN_IDLE;
            endcase
        end
    end

    // Output side: offers the head token and pops it on acknowledge.
    out_state_e out_state_q, out_state_d;
    logic       req_out_q, req_out_d;

    always_comb begin
        out_state_d = out_state_q;
        req_out_d   = req_out_q;
        pop         = 1'b0;
        case (out_state_q)
            OUT_IDLE: begin
                if (PHASES == PH_2) begin
                    if (valid[DEPTH-1] && (ack_s == req_out_q)) begin
                        req_out_d   = ~req_out_q;
                        out_state_d = OUT_REQ;
                    end
                end else if (valid[DEPTH-1] && !ack_s) begin
                    req_out_d   = 1'b1;
                    out_state_d = OUT_REQ;
                end
            end
            OUT_REQ: begin
                if (PHASES == PH_2) begin
                    if (ack_s == req_out_q) begin
                        pop         = 1'b1;
                        out_state_d = OUT_IDLE;
                    end
                end else if (ack_s) begin
                    req_out_d   = 1'b0;
                    pop         = 1'b1;
                    out_state_d = OUT_IDLE;
                end
            end
            default: out_state_d = OUT_IDLE;
        endcase
    end

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !load) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_state_q  <= IN_IDLE;
            ack_out_q   <= 1'b0;
            out_state_q <= OUT_IDLE;
            req_out_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            in_state_q  <= in_state_d;
            ack_out_q   <= ack_out_d;
            out_state_q <= out_state_d;
            req_out_q   <= req_out_d;
            count_q     <= count_d;
        end
    end

    assign ack_out  = ack_out_q;
    assign req_out  = req_out_q;
    assign data_out = data[DEPTH-1];
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));

endmodule

// File: tb/tb_hs_pipeline.sv
// Directed bench for hs_pipeline: three instances cover 4-phase with synchronisers,
// 4-phase without synchronisers and 2-phase signalling.
module tb_hs_pipeline;

    localparam int TMO = 40;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // a: PHASES=4, SYNC_STAGES=2
    logic       req_a = 1'b0, ack_in_a = 1'b0;
    logic [2:0] din_a = '0;
    logic       ack_out_a, req_out_a, empty_a, full_a;
    logic [2:0] dout_a, count_a;
    // b: PHASES=4, SYNC_STAGES=0
    logic       req_b = 1'b0, ack_in_b = 1'b0;
    logic [2:0] din_b = '0;
    logic       ack_out_b, req_out_b, empty_b, full_b;
    logic [2:0] dout_b, count_b;
    // c: PHASES=2, SYNC_STAGES=0
    logic       req_c = 1'b0, ack_in_c = 1'b0;
    logic [2:0] din_c = '0;
    logic       ack_out_c, req_out_c, empty_c, full_c;
    logic [2:0] dout_c, count_c;

    hs_pipeline #(.WIDTH(3), .DEPTH(4), .PHASES(4), .SYNC_STAGES(2)) u_dut_a (
        .clk(clk), .rst(rst), .req_in(req_a), .ack_out(ack_out_a), .data_in(din_a),
        .req_out(req_out_a), .ack_in(ack_in_a), .data_out(dout_a), .count(count_a),
        .empty(empty_a), .full(full_a)
    );

    hs_pipeline #(.WIDTH(3), .DEPTH(4), .PHASES(4), .SYNC_STAGES(0)) u_dut_b (
        .clk(clk), .rst(rst), .req_in(req_b), .ack_out(ack_out_b), .data_in(din_b),
        .req_out(req_out_b), .ack_in(ack_in_b), .data_out(dout_b), .count(count_b),
        .empty(empty_b), .full(full_b)
    );

    hs_pipeline #(.WIDTH(3), .DEPTH(4), .PHASES(2), .SYNC_STAGES(0)) u_dut_c (
        .clk(clk), .rst(rst), .req_in(req_c), .ack_out(ack_out_c), .data_in(din_c),
        .req_out(req_out_c), .ack_in(ack_in_c), .data_out(dout_c), .count(count_c),
        .empty(empty_c), .full(full_c)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Level-toggle counters for the 2-phase instance.
    int   tog_ack_c = 0, tog_req_c = 0;
    logic prev_ack_c = 1'b0, prev_req_c = 1'b0;

    always @(negedge clk) begin
        if (ack_out_c != prev_ack_c) tog_ack_c <= tog_ack_c + 1;
        if (req_out_c != prev_req_c) tog_req_c <= tog_req_c + 1;
        prev_ack_c <= ack_out_c;
        prev_req_c <= req_out_c;
    end

    task automatic push_a(input logic [2:0] v, input string tag);
        int t = 0;
        din_a = v;
        req_a = 1'b1;
        while (!ack_out_a && t < TMO) begin @(negedge clk); t++; end
        check({tag, "_ack"}, ack_out_a, 1);
        req_a = 1'b0;
        t = 0;
        while (ack_out_a && t < TMO) begin @(negedge clk); t++; end
        check({tag, "_rel"}, ack_out_a, 0);
    endtask

    task automatic pop_a(input logic [2:0] exp, input string tag);
        int t = 0;
        while (!req_out_a && t < TMO) begin @(negedge clk); t++; end
        check({tag, "_req"}, req_out_a, 1);
        check(tag, dout_a, exp);
        ack_in_a = 1'b1;
        t = 0;
        while (req_out_a && t < TMO) begin @(negedge clk); t++; end
        check({tag, "_pop"}, req_out_a, 0);
        ack_in_a = 1'b0;
    endtask

    task automatic push_b(input logic [2:0] v, input string tag);
        int t = 0;
        din_b = v;
        req_b = 1'b1;
        while (!ack_out_b && t < TMO) begin @(negedge clk); t++; end
        check({tag, "_ack"}, ack_out_b, 1);
        req_b = 1'b0;
        t = 0;
        while (ack_out_b && t < TMO) begin @(negedge clk); t++; end
        check({tag, "_rel"}, ack_out_b, 0);
    endtask

    task automatic pop_b(input logic [2:0] exp, input string tag);
        int t = 0;
        while (!req_out_b && t < TMO) begin @(negedge clk); t++; end
        check({tag, "_req"}, req_out_b, 1);
        check(tag, dout_b, exp);
        ack_in_b = 1'b1;
        t = 0;
        while (req_out_b && t < TMO) begin @(negedge clk); t++; end
        check({tag, "_pop"}, req_out_b, 0);
        ack_in_b = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int         t, lat, held, min_cnt, spurious, ta0, tr0;
        logic [2:0] exp_c [3];
        logic [2:0] sb [$];

        exp_c[0] = 3'd7; exp_c[1] = 3'd0; exp_c[2] = 3'd6;

        repeat (3) @(negedge clk);
        check("rst_count_a", count_a, 0);
        check("rst_empty_a", empty_a, 1);
        check("rst_full_a", full_a, 0);
        check("rst_req_out_a", req_out_a, 0);
        check("rst_ack_out_a", ack_out_a, 0);
        check("rst_req_out_c", req_out_c, 0);
        check("rst_ack_out_c", ack_out_c, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single-token latency through synchronisers and four stages.
        din_a = 3'b101;
        req_a = 1'b1;
        lat   = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (req_out_a && lat == 0) lat = i;
        end
        check("lat_edges", lat, 7);
        check("lat_data", dout_a, 3'b101);
        check("lat_count", count_a, 1);
        check("lat_ack_out", ack_out_a, 1);
        req_a = 1'b0;
        t = 0;
        while (ack_out_a && t < TMO) begin @(negedge clk); t++; end
        check("lat_ack_rel", ack_out_a, 0);
        pop_a(3'b101, "lat_pop");
        repeat (4) @(negedge clk);
        check("lat_empty", empty_a, 1);

        // Fill with a stalled consumer; the fifth token waits for a pop.
        push_a(3'd1, "fill1");
        push_a(3'd2, "fill2");
        push_a(3'd3, "fill3");
        push_a(3'd4, "fill4");
        repeat (4) @(negedge clk);
        check("fill_count", count_a, 4);
        check("fill_full", full_a, 1);
        din_a = 3'd5;
        req_a = 1'b1;
        held  = 0;
        repeat (12) begin
            @(negedge clk);
            if (ack_out_a) held = 1;
        end
        check("fill_ack_withheld", held, 0);
        check("fill_count_held", count_a, 4);
        check("fill_head_req", req_out_a, 1);
        check("fill_head_data", dout_a, 1);
        ack_in_a = 1'b1;
        min_cnt  = count_a;
        t = 0;
        while (!ack_out_a && t < TMO) begin
            @(negedge clk);
            t++;
            if (count_a < min_cnt) min_cnt = count_a;
        end
        check("full_pop_load_ack", ack_out_a, 1);
        check("full_pop_load_count", min_cnt, 4);
        check("full_pop_req_drop", req_out_a, 0);
        req_a    = 1'b0;
        ack_in_a = 1'b0;
        t = 0;
        while (ack_out_a && t < TMO) begin @(negedge clk); t++; end
        check("fill5_rel", ack_out_a, 0);
        pop_a(3'd2, "order2");
        pop_a(3'd3, "order3");
        pop_a(3'd4, "order4");
        pop_a(3'd5, "order5");
        repeat (4) @(negedge clk);
        check("drain_count", count_a, 0);
        check("drain_empty", empty_a, 1);

        // Asynchronous reset with three tokens held and a handshake open.
        push_a(3'd6, "rst_tok1");
        push_a(3'd5, "rst_tok2");
        din_a = 3'd3;
        req_a = 1'b1;
        t = 0;
        while (!ack_out_a && t < TMO) begin @(negedge clk); t++; end
        repeat (6) @(negedge clk);
        check("pre_rst_count", count_a, 3);
        check("pre_rst_head", dout_a, 6);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_count", count_a, 0);
        check("mid_rst_empty", empty_a, 1);
        check("mid_rst_req_out", req_out_a, 0);
        check("mid_rst_ack_out", ack_out_a, 0);
        check("mid_rst_data", dout_a, 0);
        req_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        spurious = 0;
        repeat (20) begin
            @(negedge clk);
            if (req_out_a || ack_out_a || count_a != 0) spurious = 1;
        end
        check("post_rst_quiet", spurious, 0);

        // Push and pop on one edge at count 2.
        push_b(3'd1, "sim_tok1");
        push_b(3'd2, "sim_tok2");
        repeat (6) @(negedge clk);
        check("sim_count_pre", count_b, 2);
        check("sim_req_pre", req_out_b, 1);
        check("sim_head_pre", dout_b, 1);
        din_b    = 3'd4;
        req_b    = 1'b1;
        ack_in_b = 1'b1;
        @(negedge clk);
        check("sim_count_post", count_b, 2);
        check("sim_ack_out", ack_out_b, 1);
        check("sim_req_drop", req_out_b, 0);
        req_b    = 1'b0;
        ack_in_b = 1'b0;
        @(negedge clk);
        check("sim_ack_rel", ack_out_b, 0);
        pop_b(3'd2, "sim_out2");
        pop_b(3'd4, "sim_out4");
        repeat (3) @(negedge clk);
        check("sim_drain", count_b, 0);

        // Streaming 100 random tokens against a scoreboard.
        fork
            begin : producer
                int         tp;
                logic [2:0] v;
                for (int i = 0; i < 100; i++) begin
                    v     = 3'($urandom_range(0, 7));
                    din_b = v;
                    req_b = 1'b1;
                    tp = 0;
                    while (!ack_out_b && tp < TMO) begin @(negedge clk); tp++; end
                    if (!ack_out_b) check("stream_ack_timeout", ack_out_b, 1);
                    sb.push_back(v);
                    req_b = 1'b0;
                    tp = 0;
                    while (ack_out_b && tp < TMO) begin @(negedge clk); tp++; end
                end
            end
            begin : consumer
                int tc;
                for (int i = 0; i < 100; i++) begin
                    tc = 0;
                    while (!req_out_b && tc < TMO) begin @(negedge clk); tc++; end
                    if (!req_out_b) check("stream_req_timeout", req_out_b, 1);
                    if (sb.size() == 0) check("stream_unexpected_token", 1, 0);
                    else check("stream_data", dout_b, sb.pop_front());
                    ack_in_b = 1'b1;
                    tc = 0;
                    while (req_out_b && tc < TMO) begin @(negedge clk); tc++; end
                    ack_in_b = 1'b0;
                end
            end
        join
        repeat (4) @(negedge clk);
        check("stream_sb_left", sb.size(), 0);
        check("stream_count", count_b, 0);

        // 2-phase transition signalling.
        ta0 = tog_ack_c;
        tr0 = tog_req_c;
        for (int i = 0; i < 3; i++) begin
            din_c = exp_c[i];
            req_c = ~req_c;
            t = 0;
            while ((ack_out_c != req_c) && t < TMO) begin @(negedge clk); t++; end
            check("p2_ack_level", ack_out_c, req_c);
        end
        repeat (8) @(negedge clk);
        check("p2_count", count_c, 3);
        for (int i = 0; i < 3; i++) begin
            t = 0;
            while ((req_out_c == ack_in_c) && t < TMO) begin @(negedge clk); t++; end
            check("p2_req_pending", req_out_c != ack_in_c, 1);
            check("p2_data", dout_c, exp_c[i]);
            ack_in_c = req_out_c;
        end
        repeat (6) @(negedge clk);
        check("p2_drain", count_c, 0);
        check("p2_ack_toggles", tog_ack_c - ta0, 3);
        check("p2_req_toggles", tog_req_c - tr0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
